bcd_seg_scan: RTL and testbench

BCD_SEG_SCAN -- requirements
Module: bcd_seg_scan

---
 rtl/bcd_seg_scan.sv | 124 ++++++++++++
 tb/tb_bcd_seg_scan.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_seg_scan.sv
// rtl/bcd_seg_scan.sv - four-digit BCD seven-segment scanner with frame-aligned update (optional BCD_SEG_SCAN_LZB_EN)
module bcd_seg_scan #(
  parameter int PRESCALE = 1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        err
);

  localparam logic [15:0] LAST = 16'(PRESCALE - 1);

  logic [15:0] presc;
  logic [1:0]  idx;
  logic [15:0] pend;
  logic [15:0] disp;
  logic        pend_full;
  logic        active;

  logic        tick;
  logic        frame;
  logic        xfer;
  logic        bad;
  logic        full_next;
  logic [3:0]  cur_digit;
  logic        blank;
  logic [6:0]  seg_next;

  // Scan timing, handshake and occupancy of the pending buffer
  always_comb begin
    tick      = active && (presc == LAST);
    frame     = tick && (idx == 2'd3);
    xfer      = din_valid && din_ready;
    bad       = (din[3:0] > 4'd9) || (din[7:4] > 4'd9) ||
                (din[11:8] > 4'd9) || (din[15:12] > 4'd9);
    full_next = xfer || (pend_full && !frame);
  end

  // Segment pattern for the digit currently selected by the index
  always_comb begin
    cur_digit = disp[{idx, 2'b00} +: 4];
    blank     = 1'b0;
`ifdef BCD_SEG_SCAN_LZB_EN
    case (idx)
      2'd3:    blank = (disp[15:12] == 4'd0);
      2'd2:    blank = (disp[15:8] == 8'd0);
      2'd1:    blank = (disp[15:4] == 12'd0);
      default: blank = 1'b0;
    endcase
`endif
    case (cur_digit)
      4'd0:    seg_next = 7'h40;
      4'd1:    seg_next = 7'h79;
      4'd2:    seg_next = 7'h24;
      4'd3:    seg_next = 7'h30;
      4'd4:    seg_next = 7'h19;
      4'd5:    seg_next = 7'h12;
      4'd6:    seg_next = 7'h02;
      4'd7:    seg_next = 7'h78;
      4'd8:    seg_next = 7'h00;
      4'd9:    seg_next = 7'h10;
      default: seg_next = 7'h7F;
    endcase
    if (blank) begin
      seg_next = 7'h7F;
    end
  end

  // Prescaler and digit index; both stay parked until the cycle after reset release
  always_ff @(posedge clock) begin
    if (!reset) begin
      active <= 1'b0;
      presc  <= 16'd0;
      idx    <= 2'd0;
    end else begin
      active <= 1'b1;
      if (active) begin
        presc <= tick ? 16'd0 : presc + 16'd1;
      end
      if (tick) begin
        idx <= idx + 2'd1;
      end
    end
  end

  // Pending buffer, display register and sticky error; display only moves at a frame boundary
  always_ff @(posedge clock) begin
    if (!reset) begin
      pend      <= 16'd0;
      pend_full <= 1'b0;
      disp      <= 16'd0;
      err       <= 1'b0;
      din_ready <= 1'b0;
    end else begin
      if (xfer) begin
        pend <= din;
        if (bad) begin
          err <= 1'b1;
        end
      end
      if (frame && pend_full) begin
        disp <= pend;
      end
      pend_full <= full_next;
      din_ready <= !full_next;
    end
  end

  // Registered digit drive; held dark until the scan is running
  always_ff @(posedge clock) begin
    if (!reset) begin
      seg <= 7'h7F;
      an  <= 4'hF;
    end else if (active) begin
      seg <= seg_next;
      an  <= ~(4'b0001 << idx);
    end
  end

endmodule

// File: tb/tb_bcd_seg_scan.sv
// tb/tb_bcd_seg_scan.sv - self-checking bench for bcd_seg_scan (PRESCALE = 4)
module tb_bcd_seg_scan;

  localparam int unsigned P = 4;

  logic        clock;
  logic        reset;
  logic [15:0] din;
  logic        din_valid;
  logic        din_ready;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        err;

  int vectors = 0;
  int miscompares = 0;

  bcd_seg_scan #(.PRESCALE(P)) dut (
    .clock(clock), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .seg(seg), .an(an), .err(err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  int unsigned m_t;
  logic        m_active;
  logic        m_full;
  logic [15:0] m_pend;
  logic [15:0] m_disp;
  logic        m_err;
  logic        m_ready;
  logic [6:0]  m_seg;
  logic [3:0]  m_an;
  logic        started = 1'b0;
  logic [1:0]  m_d;
  logic        m_xfer;
  logic        m_fb;

  function automatic logic [6:0] exp_seg(input logic [15:0] v, input logic [1:0] d);
    logic [15:0] sh;
    sh = v >> {d, 2'b00};
`ifdef BCD_SEG_SCAN_LZB_EN
    if (d != 2'd0 && sh == 16'd0) return 7'h7F;
`endif
    case (sh[3:0])
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic has_bad(input logic [15:0] v);
    for (int i = 0; i < 4; i++) begin
      if (((v >> (4 * i)) & 16'hF) > 16'd9) return 1'b1;
    end
    return 1'b0;
  endfunction

  always_comb begin
    m_d    = 2'((m_t / P) % 4);
    m_xfer = din_valid && m_ready;
    m_fb   = m_active && ((m_t % (4 * P)) == (4 * P - 1));
  end

  always @(posedge clock) begin
    started <= 1'b1;
    if (!reset) begin
      m_t <= 0; m_active <= 1'b0; m_full <= 1'b0; m_pend <= 16'd0; m_disp <= 16'd0;
      m_err <= 1'b0; m_ready <= 1'b0; m_seg <= 7'h7F; m_an <= 4'hF;
    end else begin
      if (m_active) begin
        m_an  <= ~(4'b0001 << m_d);
        m_seg <= exp_seg(m_disp, m_d);
        m_t   <= m_t + 1;
      end
      if (m_fb && m_full) m_disp <= m_pend;
      if (m_xfer) begin
        m_pend <= din;
        if (has_bad(din)) m_err <= 1'b1;
      end
      m_full   <= m_xfer || (m_full && !m_fb);
      m_ready  <= !(m_xfer || (m_full && !m_fb));
      m_active <= 1'b1;
    end
  end

  // every-cycle comparison against the model
  always @(negedge clock) begin
    if (started) begin
      vectors++;
      if (seg !== m_seg || an !== m_an || din_ready !== m_ready || err !== m_err) begin
        miscompares++;
        $display("FAIL cycle t=%0t seg/an/ready/err got %h %h %b %b expected %h %h %b %b",
                 $time, seg, an, din_ready, err, m_seg, m_an, m_ready, m_err);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [15:0] v, output int waited);
    int n;
    n = 0;
    din = v;
    din_valid = 1'b1;
    while (!din_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("send_timeout", 32'(n < 200), 32'd1);
    @(negedge clock);
    din_valid = 1'b0;
    waited = n;
    chk("ready_fall", 32'(din_ready), 32'd0);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!din_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("ready_timeout", 32'(n < 200), 32'd1);
  endtask

  task automatic check_digit(input logic [1:0] d, input logic [6:0] exp);
    int n;
    n = 0;
    while (an !== 4'(~(4'b0001 << d)) && n < 64) begin
      @(negedge clock);
      n++;
    end
    chk($sformatf("digit%0d_an_timeout", d), 32'(n < 64), 32'd1);
    chk($sformatf("digit%0d_seg", d), 32'(seg), 32'(exp));
  endtask

  function automatic logic [6:0] zero_seg(input logic [1:0] d);
`ifdef BCD_SEG_SCAN_LZB_EN
    if (d != 2'd0) return 7'h7F;
`endif
    return 7'h40;
  endfunction

  initial begin
    int w;
    int n;
    reset = 1'b0;
    din = 16'd0;
    din_valid = 1'b0;

    // reset release
    repeat (3) @(negedge clock);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_ready", 32'(din_ready), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    chk("rel1_ready", 32'(din_ready), 32'd1);
    chk("rel1_an", 32'(an), 32'hF);
    @(negedge clock);
    chk("rel2_an", 32'(an), 32'hE);
    chk("rel2_seg", 32'(seg), 32'h40);
    repeat (3) @(negedge clock);
    chk("rel5_an", 32'(an), 32'hE);
    @(negedge clock);
    chk("rel6_an", 32'(an), 32'hD);
    chk("rel6_seg", 32'(seg), 32'(zero_seg(2'd1)));
    check_digit(2'd2, zero_seg(2'd2));
    check_digit(2'd3, zero_seg(2'd3));

    // single transfer 1234
    send(16'h1234, w);
    wait_ready();
    check_digit(2'd0, 7'h19);
    check_digit(2'd1, 7'h30);
    check_digit(2'd2, 7'h24);
    check_digit(2'd3, 7'h79);

    // backpressure: 1234 pending, 5678 held valid
    send(16'h1234, w);
    send(16'h5678, w);
    chk("bp_waited", 32'(w > 0), 32'd1);
    check_digit(2'd1, 7'h30);
    check_digit(2'd2, 7'h24);
    check_digit(2'd3, 7'h79);
    check_digit(2'd0, 7'h00);
    check_digit(2'd1, 7'h78);
    check_digit(2'd2, 7'h02);
    check_digit(2'd3, 7'h12);

    // invalid digit and sticky err
    chk("err_before", 32'(err), 32'd0);
    send(16'h12A4, w);
    chk("err_set", 32'(err), 32'd1);
    wait_ready();
    check_digit(2'd0, 7'h19);
    check_digit(2'd1, 7'h7F);
    check_digit(2'd2, 7'h24);
    check_digit(2'd3, 7'h79);
    send(16'h0000, w);
    wait_ready();
    chk("err_sticky", 32'(err), 32'd1);
    check_digit(2'd0, 7'h40);

    // reset one cycle before a frame boundary with 9999 pending
    send(16'h9999, w);
    n = 0;
    while ((m_t % (4 * P)) != (4 * P - 2) && n < 64) begin
      @(negedge clock);
      n++;
    end
    chk("mid_align_timeout", 32'(n < 64), 32'd1);
    reset = 1'b0;
    @(negedge clock);
    chk("mid_rst_an", 32'(an), 32'hF);
    chk("mid_rst_err", 32'(err), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("mid_rel_ready", 32'(din_ready), 32'd1);
    check_digit(2'd0, 7'h40);
    check_digit(2'd1, zero_seg(2'd1));
    check_digit(2'd2, zero_seg(2'd2));
    check_digit(2'd3, zero_seg(2'd3));
    check_digit(2'd0, 7'h40);
    chk("mid_ready_still", 32'(din_ready), 32'd1);

`ifdef BCD_SEG_SCAN_LZB_EN
    // leading-zero blanking
    send(16'h0040, w);
    wait_ready();
    check_digit(2'd0, 7'h40);
    check_digit(2'd1, 7'h19);
    check_digit(2'd2, 7'h7F);
    check_digit(2'd3, 7'h7F);
    send(16'h0000, w);
    wait_ready();
    check_digit(2'd0, 7'h40);
    check_digit(2'd1, 7'h7F);
    check_digit(2'd2, 7'h7F);
    check_digit(2'd3, 7'h7F);
`endif

    repeat (4) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
